mux_select_arbiter: RTL



---
 rtl/mux_select_arbiter_if.sv | 41 ++++
 rtl/mux_select_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_select_arbiter_if
// Purpose  : Bundles the request/select/enable signals between the round-robin
//            arbiter and the 4:1 tri-state mux it controls.
// Signals  : req[3:0]  request per source (0=a, 1=b, 2=c, 3=d)
//            ss1, ss0  mux select, {ss1,ss0} = granted index
//            bus_en    tri-state buffer enable
//            gnt[3:0]  one-hot grant
//            busy      arbiter is not idle
// Modports : master - arbiter side (drives selects/enables, reads req)
//            slave  - requester/mux side
// Revision : 1.0 - initial release
// ============================================================================
interface mux_select_arbiter_if;
  logic [3:0] req;
  logic       ss1;
  logic       ss0;
  logic       bus_en;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    input  req,
    output ss1,
    output ss0,
    output bus_en,
    output gnt,
    output busy
  );

  modport slave (
    output req,
    input  ss1,
    input  ss0,
    input  bus_en,
    input  gnt,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_select_arbiter
// Purpose  : Round-robin arbiter for four sources sharing a 4:1 tri-state mux.
//            Grants one source for at most BURST cycles, then forces a single
//            dead-bus TURN cycle so two drivers are never enabled together.
//            All outputs are registered.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            bus    mux_select_arbiter_if.master (req in; ss1/ss0, bus_en,
//                   gnt, busy out)
// Params   : BURST  max consecutive grant cycles per source (1..15)
// Revision : 1.0 - initial release
// ============================================================================
module mux_select_arbiter #(
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_select_arbiter_if.master   bus
);

  localparam logic [3:0] c_burst_max = 4'(BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [1:0] r_cur,   w_cur_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic [1:0] r_sel,   w_sel_nxt;
  logic       r_bus_en, w_bus_en_nxt;
  logic       r_busy;

  logic [1:0] w_win;
  logic       w_any;

  // Rotating priority scan: walk offsets from 3 down to 0 so the lowest
  // offset from ptr that has a request is the last (winning) assignment.
  always_comb begin
    w_win = r_ptr;
    w_any = |bus.req;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[r_ptr + 2'(i)]) begin
        w_win = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_cur_nxt    = r_cur;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = r_gnt;
    w_sel_nxt    = r_sel;
    w_bus_en_nxt = r_bus_en;

    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_any) begin
          w_state_nxt  = S_GRANT;
          w_cur_nxt    = w_win;
          w_cnt_nxt    = 4'd1;
          w_gnt_nxt    = 4'b0001 << w_win;
          w_sel_nxt    = w_win;
          w_bus_en_nxt = 1'b1;
        end else begin
          w_state_nxt  = S_IDLE;
          w_gnt_nxt    = 4'b0000;
          w_bus_en_nxt = 1'b0;
        end
      end

      S_GRANT: begin
        if (!bus.req[r_cur] || (r_cnt == c_burst_max)) begin
          // Release; select lines hold so the mux output stays stable
          // while the buffer is disabled.
          w_state_nxt  = S_TURN;
          w_gnt_nxt    = 4'b0000;
          w_bus_en_nxt = 1'b0;
          w_ptr_nxt    = r_cur + 2'd1;
        end else begin
          w_cnt_nxt    = r_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_gnt_nxt    = 4'b0000;
        w_bus_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_cur    <= 2'd0;
      r_cnt    <= 4'd0;
      r_gnt    <= 4'b0000;
      r_sel    <= 2'd0;
      r_bus_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cur    <= w_cur_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sel    <= w_sel_nxt;
      r_bus_en <= w_bus_en_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.ss1    = r_sel[1];
  assign bus.ss0    = r_sel[0];
  assign bus.bus_en = r_bus_en;
  assign bus.busy   = r_busy;

endmodule
`default_nettype wire
